// File: rtl/gray2rgb_color.sv
// Gray/disparity pixel to RGB colour converter with a two-stage pipeline and an output FIFO.
// Define GRAY2RGB_PSEUDOCOLOR_EN for the blue-cyan-yellow-red pseudocolour map; default is grayscale.
module gray2rgb_color #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_gray,
  input  logic       i_DVAL,
  input  logic       i_clr,
  input  logic       i_rd_req,
  output logic [7:0] o_Red,
  output logic [7:0] o_Green,
  output logic [7:0] o_Blue,
  output logic       o_DVAL,
  output logic       o_empty,
  output logic       o_full,
  output logic       o_overflow,
  output logic       o_underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  function automatic logic [23:0] map_color(input logic [7:0] g);
`ifdef GRAY2RGB_PSEUDOCOLOR_EN
    logic [7:0] ramp;
    logic [7:0] fall;
    ramp = {g[5:0], 2'b00};
    fall = ~ramp;
    case (g[7:6])
      2'd0:    return {8'h00, ramp, 8'hFF};
      2'd1:    return {8'h00, 8'hFF, fall};
      2'd2:    return {ramp, 8'hFF, 8'h00};
      default: return {8'hFF, fall, 8'h00};
    endcase
`else
    return {g, g, g};
`endif
  endfunction

  logic [7:0]       gray_s1_q, gray_s1_d;
  logic             dval_s1_q, dval_s1_d;
  logic [23:0]      rgb_s2_q, rgb_s2_d;
  logic             dval_s2_q, dval_s2_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [23:0]      rgb_out_q, rgb_out_d;
  logic             dval_out_q, dval_out_d;
  logic [23:0]      mem [DEPTH];
  logic             fifo_empty, fifo_full, rd_acc, wr_acc, mem_we;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_COUNT);
  // No write-to-read bypass: a read needs an entry already stored.
  assign rd_acc     = i_rd_req && !fifo_empty;
  assign wr_acc     = dval_s2_q && (!fifo_full || rd_acc);

  always_comb begin
    gray_s1_d  = i_gray;
    dval_s1_d  = i_DVAL;
    rgb_s2_d   = map_color(gray_s1_q);
    dval_s2_d  = dval_s1_q;
    wr_ptr_d   = wr_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = rd_acc ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q;
    if (wr_acc && !rd_acc) count_d = count_q + CNT_W'(1);
    if (rd_acc && !wr_acc) count_d = count_q - CNT_W'(1);
    ovf_d      = ovf_q | (dval_s2_q && fifo_full && !rd_acc);
    unf_d      = unf_q | (i_rd_req && fifo_empty);
    rgb_out_d  = rd_acc ? mem[rd_ptr_q] : rgb_out_q;
    dval_out_d = rd_acc;
    mem_we     = wr_acc;
    // Flush wins over any read or write landing in the same cycle.
    if (i_clr) begin
      dval_s1_d  = 1'b0;
      dval_s2_d  = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      ovf_d      = 1'b0;
      unf_d      = 1'b0;
      rgb_out_d  = rgb_out_q;
      dval_out_d = 1'b0;
      mem_we     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_s1_q  <= '0;
      dval_s1_q  <= 1'b0;
      rgb_s2_q   <= '0;
      dval_s2_q  <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      rgb_out_q  <= '0;
      dval_out_q <= 1'b0;
    end else begin
      gray_s1_q  <= gray_s1_d;
      dval_s1_q  <= dval_s1_d;
      rgb_s2_q   <= rgb_s2_d;
      dval_s2_q  <= dval_s2_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      rgb_out_q  <= rgb_out_d;
      dval_out_q <= dval_out_d;
    end
  end

  // Storage array needs no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= rgb_s2_q;
  end

  assign o_Red       = rgb_out_q[23:16];
  assign o_Green     = rgb_out_q[15:8];
  assign o_Blue      = rgb_out_q[7:0];
  assign o_DVAL      = dval_out_q;
  assign o_empty     = fifo_empty;
  assign o_full      = fifo_full;
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;

endmodule

// File: tb/tb_gray2rgb_color.sv
// Scoreboard testbench for gray2rgb_color: queue-based reference model plus an output monitor.
// Honours GRAY2RGB_PSEUDOCOLOR_EN the same way the design does.
module tb_gray2rgb_color;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] i_gray = '0;
  logic       i_DVAL = 1'b0;
  logic       i_clr = 1'b0;
  logic       i_rd_req = 1'b0;
  logic [7:0] o_Red, o_Green, o_Blue;
  logic       o_DVAL, o_empty, o_full, o_overflow, o_underflow;

  gray2rgb_color #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .i_gray(i_gray), .i_DVAL(i_DVAL), .i_clr(i_clr),
    .i_rd_req(i_rd_req), .o_Red(o_Red), .o_Green(o_Green), .o_Blue(o_Blue),
    .o_DVAL(o_DVAL), .o_empty(o_empty), .o_full(o_full),
    .o_overflow(o_overflow), .o_underflow(o_underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int          t;
    logic [23:0] c;
  } flight_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  flight_t     inflight[$];
  logic [23:0] fifo_m[$];
  logic [23:0] exp_q[$];
  logic        m_ovf = 1'b0, m_unf = 1'b0, m_dval = 1'b0;
  logic [23:0] m_rgb = '0;

  function automatic logic [23:0] ref_color(input int g);
    int r, gr, b;
`ifdef GRAY2RGB_PSEUDOCOLOR_EN
    if (g < 64) begin
      r = 0; gr = 4 * g; b = 255;
    end else if (g < 128) begin
      r = 0; gr = 255; b = 255 - 4 * (g - 64);
    end else if (g < 192) begin
      r = 4 * (g - 128); gr = 255; b = 0;
    end else begin
      r = 255; gr = 255 - 4 * (g - 192); b = 0;
    end
`else
    r = g; gr = g; b = g;
`endif
    return {r[7:0], gr[7:0], b[7:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    inflight.delete();
    fifo_m.delete();
    exp_q.delete();
    m_ovf = 1'b0; m_unf = 1'b0; m_dval = 1'b0; m_rgb = '0;
  endtask

  // Spec-level model: a pixel sampled at edge N reaches the FIFO queue at edge N+2.
  task automatic modelStep(input logic [7:0] g, input bit dv, input bit rd, input bit clr);
    flight_t f;
    bit      have, rd_acc, full_before;
    if (clr) begin
      inflight.delete();
      fifo_m.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_dval = 1'b0;
    end else begin
      full_before = (fifo_m.size() == DEPTH);
      rd_acc = rd && (fifo_m.size() > 0);
      if (rd && fifo_m.size() == 0) m_unf = 1'b1;
      have = 1'b0;
      if (inflight.size() > 0 && inflight[0].t == cyc) begin
        f = inflight.pop_front();
        have = 1'b1;
      end
      if (rd_acc) begin
        m_rgb = fifo_m.pop_front();
        exp_q.push_back(m_rgb);
      end
      m_dval = rd_acc;
      if (have) begin
        if (!full_before || rd_acc) fifo_m.push_back(f.c);
        else m_ovf = 1'b1;
      end
      if (dv) inflight.push_back('{t: cyc + 2, c: ref_color(int'(g))});
    end
    cyc++;
  endtask

  task automatic checkOutput();
    check("o_empty", 32'(o_empty), 32'(fifo_m.size() == 0));
    check("o_full", 32'(o_full), 32'(fifo_m.size() == DEPTH));
    check("o_overflow", 32'(o_overflow), 32'(m_ovf));
    check("o_underflow", 32'(o_underflow), 32'(m_unf));
    check("o_DVAL", 32'(o_DVAL), 32'(m_dval));
    check("rgb_hold", 32'({o_Red, o_Green, o_Blue}), 32'(m_rgb));
  endtask

  task automatic applyStimulus(input logic [7:0] g, input bit dv, input bit rd, input bit clr);
    i_gray = g; i_DVAL = dv; i_rd_req = rd; i_clr = clr;
    @(posedge clk);
    modelStep(g, dv, rd, clr);
    #2;
    checkOutput();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    i_gray = '0; i_DVAL = 1'b0; i_rd_req = 1'b0; i_clr = 1'b0;
    modelReset();
    #1;
    checkOutput();
    @(posedge clk);
    #2;
    checkOutput();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every presented output pixel must match the oldest expected one.
  always @(posedge clk) begin
    #1;
    if (o_DVAL === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'({o_Red, o_Green, o_Blue}), 32'hFFFF_FFFF);
      end else begin
        check("scoreboard_pixel", 32'({o_Red, o_Green, o_Blue}), 32'(exp_q.pop_front()));
      end
    end
  end

  logic [23:0] exp29[5];
  int          pix29[5];

  initial begin
    exp29 = '{24'h0000FF, 24'h00FFFF, 24'h00FF6F, 24'hFFDF00, 24'hFF0300};
    pix29 = '{0, 64, 100, 200, 255};
    #2;
    doReset();
    check("reset_empty", 32'(o_empty), 32'd1);
    check("reset_red", 32'(o_Red), 32'd0);

    // Latency: pixel sampled at edge 0 lands in the FIFO at edge 2.
    applyStimulus(8'h5A, 1, 0, 0);
    check("lat_edge0_empty", 32'(o_empty), 32'd1);
    applyStimulus(8'h00, 0, 0, 0);
    check("lat_edge1_empty", 32'(o_empty), 32'd1);
    applyStimulus(8'h00, 0, 0, 0);
    check("lat_edge2_empty", 32'(o_empty), 32'd0);
    applyStimulus(8'h00, 0, 1, 0);
`ifndef GRAY2RGB_PSEUDOCOLOR_EN
    check("gray_5A", 32'({o_Red, o_Green, o_Blue}), 32'h5A5A5A);
`endif

    // Five reference pixels, then five reads.
    for (int k = 0; k < 5; k++) applyStimulus(8'(pix29[k]), 1, 0, 0);
    applyStimulus(8'h00, 0, 0, 0);
    applyStimulus(8'h00, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(8'h00, 0, 1, 0);
      check("read_dval", 32'(o_DVAL), 32'd1);
`ifdef GRAY2RGB_PSEUDOCOLOR_EN
      check("pseudo_color", 32'({o_Red, o_Green, o_Blue}), 32'(exp29[k]));
`endif
    end

    // Overfill with 18 pixels, then drain.
    for (int k = 1; k <= 18; k++) applyStimulus(8'(k), 1, 0, 0);
    for (int k = 0; k < 3; k++) applyStimulus(8'h00, 0, 0, 0);
    check("fill_full", 32'(o_full), 32'd1);
    check("fill_overflow", 32'(o_overflow), 32'd1);
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(8'h00, 0, 1, 0);
      check("drain_pixel", 32'(o_Red), 32'(ref_color(k) >> 16));
    end
    applyStimulus(8'h00, 0, 0, 0);
    check("drain_empty", 32'(o_empty), 32'd1);

    // Full FIFO with simultaneous read and write keeps count at DEPTH.
    applyStimulus(8'h00, 0, 0, 1);
    for (int k = 0; k < 16; k++) applyStimulus(8'(100 + k), 1, 0, 0);
    applyStimulus(8'h00, 0, 0, 0);
    applyStimulus(8'h00, 0, 0, 0);
    check("prefull", 32'(o_full), 32'd1);
    for (int k = 0; k < 6; k++) applyStimulus(8'(200 + k), 1, k >= 2, 0);
    applyStimulus(8'h00, 0, 1, 0);
    applyStimulus(8'h00, 0, 1, 0);
    check("rw_full", 32'(o_full), 32'd1);
    check("rw_no_overflow", 32'(o_overflow), 32'd0);
    for (int k = 0; k < 16; k++) applyStimulus(8'h00, 0, 1, 0);
    applyStimulus(8'h00, 0, 1, 0);
    check("empty_read_dval", 32'(o_DVAL), 32'd0);
    check("empty_read_underflow", 32'(o_underflow), 32'd1);

    // Flush with 5 pixels buffered.
    for (int k = 0; k < 5; k++) applyStimulus(8'(30 + k), 1, 0, 0);
    applyStimulus(8'h00, 0, 0, 0);
    applyStimulus(8'h00, 0, 0, 0);
    applyStimulus(8'h00, 0, 0, 1);
    check("clr_empty", 32'(o_empty), 32'd1);
    check("clr_underflow", 32'(o_underflow), 32'd0);
    applyStimulus(8'h00, 0, 1, 0);
    check("clr_read_dval", 32'(o_DVAL), 32'd0);

    // Reset in the middle of a burst discards in-flight pixels.
    for (int k = 0; k < 4; k++) applyStimulus(8'(50 + k), 1, 0, 0);
    doReset();
    applyStimulus(8'h00, 0, 0, 0);
    applyStimulus(8'h00, 0, 0, 0);
    check("rst_mid_empty", 32'(o_empty), 32'd1);
    check("rst_mid_overflow", 32'(o_overflow), 32'd0);

    // Random traffic: a write-heavy phase then a read-heavy phase.
    for (int k = 0; k < 600; k++) begin
      applyStimulus(8'($urandom_range(0, 255)), $urandom_range(0, 1) == 1,
                    (k < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                    $urandom_range(0, 99) == 0);
    end
    for (int k = 0; k < 3; k++) applyStimulus(8'h00, 0, 0, 0);
    for (int k = 0; k < DEPTH + 2; k++) applyStimulus(8'h00, 0, 1, 0);
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray2rgb_color.md
GRAY2RGB_COLOR -- requirements
Module: gray2rgb_color

Interface
REQ-001 The module SHALL have parameter DEPTH, default 16, giving the output FIFO depth in pixels; it is a power of two and at least 4.
REQ-002 The module SHALL have port clk, input, 1 bit: clock.
REQ-003 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The module SHALL have port i_gray, input, 8 bits: gray/disparity pixel.
REQ-005 The module SHALL have port i_DVAL, input, 1 bit: i_gray valid this cycle.
REQ-006 The module SHALL have port i_clr, input, 1 bit: synchronous flush.
REQ-007 The module SHALL have port i_rd_req, input, 1 bit: display-side pixel request.
REQ-008 The module SHALL have ports o_Red, o_Green, o_Blue, output, 8 bits each: colour pixel.
REQ-009 The module SHALL have port o_DVAL, output, 1 bit: o_Red/o_Green/o_Blue valid this cycle.
REQ-010 The module SHALL have ports o_empty and o_full, output, 1 bit each: FIFO status.
REQ-011 The module SHALL have ports o_overflow and o_underflow, output, 1 bit each: sticky error flags.

Function
REQ-012 Stage 1 SHALL register i_gray and i_DVAL on every clk edge.
REQ-013 Stage 2 SHALL register the 24-bit colour of the stage-1 pixel plus its valid bit; a pixel sampled at edge N is written to the FIFO at edge N+2.
REQ-014 Write accept SHALL be defined as: stage-2 valid and (not full, or a read is accepted in the same cycle).
REQ-015 A stage-2 pixel arriving while full with no read SHALL be dropped and SHALL set o_overflow; the FIFO contents are unchanged.
REQ-016 Read accept SHALL be defined as: i_rd_req and not empty; there is no write-to-read bypass, so a read when empty is never accepted even if a write lands in the same cycle.
REQ-017 On read accept at edge M, the head entry SHALL drive o_Red/o_Green/o_Blue from edge M with o_DVAL=1 for one cycle.
REQ-018 Otherwise o_DVAL SHALL be 0 and the colour outputs SHALL hold their last value.
REQ-019 i_rd_req while empty SHALL set o_underflow.
REQ-020 Occupancy SHALL be a count of width log2(DEPTH)+1; read and write pointers wrap modulo DEPTH; o_empty = (count==0) and o_full = (count==DEPTH), both registered-state derived.
REQ-021 Simultaneous read and write SHALL leave count unchanged, including when full.
REQ-022 i_clr SHALL zero the pointers, count, both sticky flags, both pipeline valid bits and o_DVAL at the next edge; it overrides a same-cycle read or write.
REQ-023 Stored pixel order SHALL equal arrival order; no pixel is duplicated.

Reset
REQ-024 While rst_n is low, all registers SHALL clear asynchronously: colour outputs 0, o_DVAL 0, o_empty 1, o_full 0, o_overflow 0, o_underflow 0, pointers/count 0, pipeline stages 0.
REQ-025 Reset mid-stream SHALL discard all buffered and in-flight pixels.
REQ-026 Normal operation SHALL resume on the first edge after rst_n deasserts.

Configuration
REQ-027 With GRAY2RGB_PSEUDOCOLOR_EN defined, the colour SHALL follow this piecewise map of g (8-bit exact, no saturation needed):
- g<64: (0, 4g, 255)
- 64<=g<128: (0, 255, 255-4(g-64))
- 128<=g<192: (4(g-128), 255, 0)
- g>=192: (255, 255-4(g-192), 0)
REQ-028 Without GRAY2RGB_PSEUDOCOLOR_EN, the colour SHALL be (g, g, g); latency and FIFO behaviour are identical in both builds.

Verification
REQ-029 PSEUDOCOLOR build, pixels 0/64/100/200/255 then five i_rd_req -> (0,0,255), (0,255,255), (0,255,111), (255,223,0), (255,3,0) in order, each with o_DVAL=1.
REQ-030 Grayscale build, pixel 0x5A then read -> (0x5A,0x5A,0x5A).
REQ-031 The bench SHALL check FIFO latency: write at edge 0 -> o_empty=0 observed only after edge 2.
REQ-032 DEPTH=16, 18 pixels, no reads -> o_full=1, o_overflow=1, 16 reads return pixels 1-16, then o_empty=1.
REQ-033 Full FIFO with simultaneous read and write -> count stays 16, o_overflow stays 0; i_rd_req on empty -> o_DVAL=0, o_underflow=1.
REQ-034 5 pixels buffered then i_clr (or rst_n low mid-burst) -> o_empty=1, flags 0, next read gives o_DVAL=0.
